vec_lsu_stride_engine: RTL and testbench

Parametrised vector load/store engine and successor to the single-mode vector LSU. It handles unit-stride, constant-stride (signed) and indexed accesses, for 8/16/32-bit elements, with per-element masking. Each element becomes one request on a req/gnt/rvalid memory port, and only one request is outstanding at a time. Loaded elements are assembled into a VLEN-bit destination word with byte enables for vector-regfile writeback.

---
 rtl/vec_lsu_stride_engine.sv | 173 +++++++++++++++++
 tb/tb_vec_lsu_stride_engine.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_lsu_stride_engine.sv
// Vector load/store sequencer: unit, signed-strided and indexed element streams.
// One memory request in flight at a time; loaded elements are packed into a VLEN-bit result.
module vec_lsu_stride_engine #(
    parameter int XLEN   = 32,
    parameter int VLEN   = 512,
    parameter int MEM_DW = 32,
    parameter int NELEM  = VLEN / 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic                ld_inst,
    input  logic [1:0]          mode,
    input  logic [1:0]          eew,
    input  logic [XLEN-1:0]     base_addr,
    input  logic [XLEN-1:0]     stride,
    input  logic [XLEN-1:0]     vl,
    input  logic                vm,
    input  logic [NELEM-1:0]    mask,
    input  logic [VLEN-1:0]     index_data,
    input  logic [VLEN-1:0]     store_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [MEM_DW-1:0]   mem_wdata,
    output logic [MEM_DW/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [MEM_DW-1:0]   mem_rdata,
    output logic [VLEN-1:0]     vd_data,
    output logic [VLEN/8-1:0]   vd_be,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam int MW  = $clog2(NELEM);
    localparam int IW  = MW + 1;
    localparam int BW  = MEM_DW / 8;
    localparam int VBW = VLEN / 8;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_RESP, S_DONE} state_t;
    state_t r_state, w_next;

    logic              r_ld, r_vm, r_error;
    logic [1:0]        r_mode, r_eew;
    logic [XLEN-1:0]   r_base, r_stride;
    logic [NELEM-1:0]  r_mask;
    logic [VLEN-1:0]   r_index, r_sdata, r_vd_data;
    logic [VBW-1:0]    r_vd_be;
    logic [IW-1:0]     r_i, r_n;

    logic [31:0]       w_byteoff, w_bitoff;
    logic [MEM_DW-1:0] w_emask, w_idx_el, w_st_el;
    logic [BW-1:0]     w_be;
    logic [XLEN-1:0]   w_addr, w_max, w_align;
    logic [VLEN-1:0]   w_vd_mask, w_vd_wr;
    logic [VBW-1:0]    w_vd_bemask;
    logic              w_skip, w_misalign, w_last, w_illegal, w_issue;

    // Element i sits at byte i<<eew of any packed VLEN word
    assign w_byteoff   = 32'(r_i) << r_eew;
    assign w_bitoff    = w_byteoff << 3;
    assign w_emask     = MEM_DW'((64'd1 << (32'd8 << r_eew)) - 64'd1);
    assign w_be        = BW'((32'd1 << (32'd1 << r_eew)) - 32'd1);
    assign w_align     = XLEN'((32'd1 << r_eew) - 32'd1);
    assign w_idx_el    = MEM_DW'(r_index >> w_bitoff) & w_emask;
    assign w_st_el     = MEM_DW'(r_sdata >> w_bitoff) & w_emask;
    assign w_vd_mask   = VLEN'(w_emask) << w_bitoff;
    assign w_vd_wr     = VLEN'(mem_rdata & w_emask) << w_bitoff;
    assign w_vd_bemask = VBW'(w_be) << w_byteoff;
    assign w_max       = XLEN'(NELEM) >> eew;

    always_comb begin
        w_addr = r_base + XLEN'(w_idx_el);
        case (r_mode)
            2'b00:   w_addr = r_base + (XLEN'(r_i) << r_eew);
            2'b01:   w_addr = r_base + XLEN'(r_i) * r_stride;
            default: ;
        endcase
    end

    assign w_skip     = !r_vm && !r_mask[r_i[MW-1:0]];
    assign w_misalign = |(w_addr & w_align);
    assign w_last     = (r_i + IW'(1)) == r_n;
    assign w_illegal  = (r_mode == 2'b11) || (r_eew == 2'b11);
    assign w_issue    = (r_state == S_REQ) && !w_skip && !w_misalign;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SETUP;
            S_SETUP: w_next = (w_illegal || r_n == '0) ? S_DONE : S_REQ;
            S_REQ: begin
                if (w_skip)          w_next = w_last ? S_DONE : S_REQ;
                else if (w_misalign) w_next = S_DONE;
                else if (mem_gnt)    w_next = r_ld ? S_RESP : (w_last ? S_DONE : S_REQ);
            end
            S_RESP:  if (mem_rvalid) w_next = w_last ? S_DONE : S_REQ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request fields are zeroed whenever no request is presented
    always_comb begin
        mem_req   = w_issue;
        mem_we    = w_issue && !r_ld;
        mem_addr  = w_issue ? w_addr : '0;
        mem_wdata = (w_issue && !r_ld) ? w_st_el : '0;
        mem_be    = w_issue ? w_be : '0;
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ld      <= 1'b0;
            r_vm      <= 1'b0;
            r_error   <= 1'b0;
            r_mode    <= '0;
            r_eew     <= '0;
            r_base    <= '0;
            r_stride  <= '0;
            r_mask    <= '0;
            r_index   <= '0;
            r_sdata   <= '0;
            r_vd_data <= '0;
            r_vd_be   <= '0;
            r_i       <= '0;
            r_n       <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_ld      <= ld_inst;
                    r_vm      <= vm;
                    r_mode    <= mode;
                    r_eew     <= eew;
                    r_base    <= base_addr;
                    r_stride  <= stride;
                    r_mask    <= mask;
                    r_index   <= index_data;
                    r_sdata   <= store_data;
                    r_error   <= 1'b0;
                    r_vd_data <= '0;
                    r_vd_be   <= '0;
                    r_i       <= '0;
                    r_n       <= IW'((vl < w_max) ? vl : w_max);
                end
                S_SETUP: if (w_illegal) r_error <= 1'b1;
                S_REQ: begin
                    if (w_skip)                    r_i <= r_i + IW'(1);
                    else if (w_misalign)           r_error <= 1'b1;
                    else if (mem_gnt && !r_ld)     r_i <= r_i + IW'(1);
                end
                S_RESP: if (mem_rvalid) begin
                    r_vd_data <= (r_vd_data & ~w_vd_mask) | w_vd_wr;
                    r_vd_be   <= r_vd_be | w_vd_bemask;
                    r_i       <= r_i + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign vd_data = r_vd_data;
    assign vd_be   = r_vd_be;
    assign error   = r_error;
endmodule

// File: tb/tb_vec_lsu_stride_engine.sv
// Bench for vec_lsu_stride_engine: directed scenarios plus random operations
// checked against an element-by-element reference model and a memory responder.
module tb_vec_lsu_stride_engine;
    localparam int XLEN = 32, VLEN = 512, MEM_DW = 32, NELEM = VLEN / 8;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start = 1'b0, ld_inst = 1'b0, vm = 1'b1;
    logic [1:0]        mode = '0, eew = '0;
    logic [XLEN-1:0]   base_addr = '0, stride = '0, vl = '0;
    logic [NELEM-1:0]  mask = '0;
    logic [VLEN-1:0]   index_data = '0, store_data = '0;
    logic              mem_req, mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [MEM_DW-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [MEM_DW-1:0] mem_rdata = '0;
    logic [VLEN-1:0]   vd_data;
    logic [VLEN/8-1:0] vd_be;
    logic              busy, done, error;

    always #5 clk = ~clk;

    vec_lsu_stride_engine #(.XLEN(XLEN), .VLEN(VLEN), .MEM_DW(MEM_DW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .ld_inst(ld_inst), .mode(mode), .eew(eew),
        .base_addr(base_addr), .stride(stride), .vl(vl), .vm(vm), .mask(mask),
        .index_data(index_data), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .vd_data(vd_data), .vd_be(vd_be), .busy(busy), .done(done), .error(error)
    );

    int n_chk = 0, n_pass = 0;

    // Responder state and observed accepted requests
    int          gnt_pct = 100, rv_dly = 0, stall_left = 0;
    bit          rv_pend = 0;
    int          rv_cnt = 0;
    logic [31:0] rv_addr = '0;
    logic [31:0] rdata_q[$];
    logic [31:0] o_addr[$], o_wdata[$], stall_addr[$];
    logic        o_we[$];
    logic [3:0]  o_be[$];

    // Expected results from the reference model
    logic [31:0]       e_addr[$], e_wdata[$];
    logic              e_we[$];
    logic [3:0]        e_be[$];
    logic [VLEN-1:0]   e_vd;
    logic [VLEN/8-1:0] e_vdbe;
    logic              e_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A51F27;
    endfunction

    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (n_rst !== 1'b1) begin
            rv_pend = 0;
        end else begin
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    if (rdata_q.size() > 0) mem_rdata = rdata_q.pop_front();
                    else                    mem_rdata = mem_word(rv_addr);
                    rv_pend = 0;
                end else rv_cnt--;
            end
            if (mem_req === 1'b1) begin
                if (stall_left > 0) begin
                    stall_left--;
                    stall_addr.push_back(mem_addr);
                end else if (int'($urandom_range(99)) < gnt_pct) begin
                    mem_gnt = 1'b1;
                    o_addr.push_back(mem_addr);
                    o_we.push_back(mem_we);
                    o_wdata.push_back(mem_wdata);
                    o_be.push_back(mem_be);
                    if (!mem_we) begin
                        rv_pend = 1;
                        rv_cnt  = (rv_dly < 0) ? int'($urandom_range(3)) : rv_dly;
                        rv_addr = mem_addr;
                    end
                end
            end
        end
    end

    // Walks the element list as an architectural description of the operation
    task automatic build_expect();
        int esz, lim, n;
        logic [31:0] a, el, w;
        e_addr.delete(); e_wdata.delete(); e_we.delete(); e_be.delete();
        e_vd = '0; e_vdbe = '0; e_err = 0;
        if (mode == 2'b11 || eew == 2'b11) begin e_err = 1; return; end
        esz = 1 << eew;
        lim = VLEN / (8 * esz);
        n   = (vl > 32'(lim)) ? lim : int'(vl);
        for (int k = 0; k < n; k++) begin
            if (!vm && !mask[k]) continue;
            el = '0;
            for (int b = 0; b < esz; b++) el[8*b +: 8] = index_data[(k*esz+b)*8 +: 8];
            case (mode)
                2'b00:   a = base_addr + 32'(k * esz);
                2'b01:   a = base_addr + 32'(k) * stride;
                default: a = base_addr + el;
            endcase
            if (a % esz != 0) begin e_err = 1; break; end
            el = '0;
            for (int b = 0; b < esz; b++) el[8*b +: 8] = store_data[(k*esz+b)*8 +: 8];
            e_addr.push_back(a);
            e_we.push_back(!ld_inst);
            e_wdata.push_back(ld_inst ? 32'h0 : el);
            e_be.push_back(4'((1 << esz) - 1));
            if (ld_inst) begin
                w = mem_word(a);
                for (int b = 0; b < esz; b++) begin
                    e_vd[(k*esz+b)*8 +: 8] = w[8*b +: 8];
                    e_vdbe[k*esz+b] = 1'b1;
                end
            end
        end
    endtask

    task automatic run_op(input bit poke, output int cyc, output bit post_done, output bit post_busy);
        bit got;
        o_addr.delete(); o_we.delete(); o_wdata.delete(); o_be.delete(); stall_addr.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; got = 0;
        while (!got && cyc < 3000) begin
            if (done === 1'b1) got = 1;
            else begin
                if (poke && cyc == 3) begin start = 1'b1; base_addr = 32'hDEAD0000; end
                if (poke && cyc == 4) start = 1'b0;
                @(negedge clk); cyc++;
            end
        end
        n_chk++; if (!got) $display("FAIL done_timeout: no done after %0d cycles", cyc); else n_pass++;
        @(negedge clk);
        post_done = done;
        post_busy = busy;
    endtask

    task automatic set_op(input bit ld, input logic [1:0] md, input logic [1:0] ew,
                          input logic [31:0] ba, input logic [31:0] st, input logic [31:0] n);
        ld_inst = ld; mode = md; eew = ew; base_addr = ba; stride = st; vl = n;
        vm = 1'b1; mask = '0; index_data = '0; store_data = '0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #1;
        n_chk++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, done, error} !== '0)
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h be=%h busy=%b done=%b err=%b want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, done, error);
        else n_pass++;
        n_chk++; if (vd_data !== '0 || vd_be !== '0)
            $display("FAIL reset_vd: got vd_be=%h want 0", vd_be); else n_pass++;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unit_load();
        int cyc; bit pd, pb;
        set_op(1, 2'b00, 2'd2, 32'h100, 0, 4);
        gnt_pct = 100; rv_dly = 0;
        rdata_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_op(0, cyc, pd, pb);
        n_chk++; if (o_addr.size() != 4) $display("FAIL ul_count: got %0d want 4", o_addr.size()); else n_pass++;
        for (int k = 0; k < o_addr.size() && k < 4; k++) begin
            n_chk++; if (o_addr[k] !== 32'h100 + 32'(4*k) || o_we[k] !== 1'b0 || o_be[k] !== 4'hF)
                $display("FAIL ul_req%0d: got addr=%h we=%b be=%h want %h 0 f", k, o_addr[k], o_we[k], o_be[k], 32'h100 + 32'(4*k));
            else n_pass++;
        end
        n_chk++; if (vd_data !== {384'h0, 128'h000000A3_000000A2_000000A1_000000A0})
            $display("FAIL ul_vd_data: got %h", vd_data[127:0]); else n_pass++;
        n_chk++; if (vd_be !== 64'hFFFF) $display("FAIL ul_vd_be: got %h want ffff", vd_be); else n_pass++;
        n_chk++; if (cyc != 10) $display("FAIL ul_latency: got %0d want 10", cyc); else n_pass++;
        n_chk++; if (pd !== 1'b0 || pb !== 1'b0 || error !== 1'b0)
            $display("FAIL ul_post: got done=%b busy=%b err=%b want 0 0 0", pd, pb, error); else n_pass++;
    endtask

    task automatic test_neg_stride_store();
        int cyc; bit pd, pb;
        logic [31:0] ea [3] = '{32'h20, 32'h1D, 32'h1A};
        logic [31:0] ed [3] = '{32'h11, 32'h22, 32'h33};
        set_op(0, 2'b01, 2'd0, 32'h20, 32'hFFFFFFFD, 3);
        store_data[23:0] = 24'h332211;
        run_op(0, cyc, pd, pb);
        n_chk++; if (o_addr.size() != 3) $display("FAIL ns_count: got %0d want 3", o_addr.size()); else n_pass++;
        for (int k = 0; k < o_addr.size() && k < 3; k++) begin
            n_chk++; if (o_addr[k] !== ea[k] || o_wdata[k] !== ed[k] || o_we[k] !== 1'b1 || o_be[k] !== 4'h1)
                $display("FAIL ns_req%0d: got addr=%h wdata=%h we=%b be=%h want %h %h 1 1",
                         k, o_addr[k], o_wdata[k], o_we[k], o_be[k], ea[k], ed[k]);
            else n_pass++;
        end
        n_chk++; if (cyc != 5) $display("FAIL ns_latency: got %0d want 5", cyc); else n_pass++;
        n_chk++; if (vd_be !== '0) $display("FAIL ns_vd_be: got %h want 0", vd_be); else n_pass++;
    endtask

    task automatic test_indexed_mask();
        int cyc; bit pd, pb;
        logic [31:0] w1, w3;
        set_op(1, 2'b10, 2'd1, 32'h200, 0, 4);
        vm = 1'b0; mask[3:0] = 4'b1010;
        index_data[63:0] = 64'h0002_0004_0008_0000;
        w1 = mem_word(32'h208); w3 = mem_word(32'h202);
        run_op(0, cyc, pd, pb);
        n_chk++; if (o_addr.size() != 2) $display("FAIL ix_count: got %0d want 2", o_addr.size()); else n_pass++;
        if (o_addr.size() == 2) begin
            n_chk++; if (o_addr[0] !== 32'h208 || o_addr[1] !== 32'h202 || o_be[0] !== 4'h3)
                $display("FAIL ix_addrs: got %h %h be=%h want 208 202 3", o_addr[0], o_addr[1], o_be[0]);
            else n_pass++;
        end
        n_chk++; if (vd_be !== 64'h00CC) $display("FAIL ix_vd_be: got %h want cc", vd_be); else n_pass++;
        n_chk++; if (vd_data !== {448'h0, w3[15:0], 16'h0, w1[15:0], 16'h0})
            $display("FAIL ix_vd_data: got %h want %h", vd_data[63:0], {w3[15:0], 16'h0, w1[15:0], 16'h0});
        else n_pass++;
        n_chk++; if (cyc != 8) $display("FAIL ix_latency: got %0d want 8", cyc); else n_pass++;
    endtask

    task automatic test_edge_cases();
        int cyc; bit pd, pb;
        set_op(1, 2'b00, 2'd2, 32'h100, 0, 0);
        run_op(0, cyc, pd, pb);
        n_chk++; if (cyc != 2 || o_addr.size() != 0 || error !== 1'b0)
            $display("FAIL vl0: got cyc=%0d reqs=%0d err=%b want 2 0 0", cyc, o_addr.size(), error);
        else n_pass++;
        set_op(1, 2'b11, 2'd2, 32'h100, 0, 4);
        run_op(0, cyc, pd, pb);
        n_chk++; if (error !== 1'b1 || o_addr.size() != 0 || cyc != 2)
            $display("FAIL mode11: got err=%b reqs=%0d cyc=%0d want 1 0 2", error, o_addr.size(), cyc);
        else n_pass++;
        set_op(1, 2'b00, 2'd2, 32'h102, 0, 2);
        run_op(0, cyc, pd, pb);
        n_chk++; if (error !== 1'b1 || o_addr.size() != 0 || cyc != 3 || vd_be !== '0)
            $display("FAIL misalign: got err=%b reqs=%0d cyc=%0d be=%h want 1 0 3 0", error, o_addr.size(), cyc, vd_be);
        else n_pass++;
        @(negedge clk);
        n_chk++; if (error !== 1'b1) $display("FAIL err_sticky: got %b want 1", error); else n_pass++;
    endtask

    task automatic test_grant_stall();
        int cyc; bit pd, pb;
        set_op(0, 2'b00, 2'd2, 32'h40, 0, 2);
        store_data[63:0] = {$urandom, $urandom};
        stall_left = 5;
        run_op(1, cyc, pd, pb);
        n_chk++; if (stall_addr.size() != 5) $display("FAIL st_len: got %0d want 5", stall_addr.size()); else n_pass++;
        foreach (stall_addr[k]) begin
            n_chk++; if (stall_addr[k] !== 32'h40) $display("FAIL st_addr%0d: got %h want 40", k, stall_addr[k]); else n_pass++;
        end
        n_chk++; if (o_addr.size() != 2) $display("FAIL st_count: got %0d want 2", o_addr.size()); else n_pass++;
        if (o_addr.size() == 2) begin
            n_chk++; if (o_addr[0] !== 32'h40 || o_addr[1] !== 32'h44 ||
                         o_wdata[0] !== store_data[31:0] || o_wdata[1] !== store_data[63:32])
                $display("FAIL st_reqs: got %h/%h %h/%h", o_addr[0], o_wdata[0], o_addr[1], o_wdata[1]);
            else n_pass++;
        end
        n_chk++; if (cyc != 9 || error !== 1'b0 || pd !== 1'b0)
            $display("FAIL st_done: got cyc=%0d err=%b post_done=%b want 9 0 0", cyc, error, pd);
        else n_pass++;
        stall_left = 0;
    endtask

    task automatic test_random();
        int cyc, esz, s; bit pd, pb;
        logic [31:0] v;
        for (int it = 0; it < 40; it++) begin
            ld_inst = 1'($urandom_range(1));
            mode    = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
            eew     = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
            esz     = (eew == 2'b11) ? 1 : (1 << eew);
            base_addr = 32'($urandom_range(16'hFFFF)) & ~32'(esz - 1);
            if ($urandom_range(9) == 0) base_addr = base_addr | 32'h1;
            s       = int'($urandom_range(16)) - 8;
            stride  = 32'(s * esz);
            vl      = ($urandom_range(7) == 0) ? 32'd1000 : 32'($urandom_range(20));
            vm      = 1'($urandom_range(1));
            mask    = {$urandom, $urandom};
            for (int k = 0; k < VLEN / (8 * esz); k++) begin
                v = 32'($urandom_range(63) * esz);
                if ($urandom_range(19) == 0) v = v + 1;
                for (int b = 0; b < esz; b++) index_data[(k*esz+b)*8 +: 8] = v[8*b +: 8];
            end
            for (int w = 0; w < VLEN / 32; w++) store_data[32*w +: 32] = $urandom;
            gnt_pct = int'($urandom_range(40, 100));
            rv_dly  = -1;
            build_expect();
            run_op(0, cyc, pd, pb);
            n_chk++; if (o_addr.size() != e_addr.size())
                $display("FAIL rnd%0d_count: got %0d want %0d", it, o_addr.size(), e_addr.size());
            else n_pass++;
            for (int k = 0; k < o_addr.size() && k < e_addr.size(); k++) begin
                n_chk++; if (o_addr[k] !== e_addr[k] || o_we[k] !== e_we[k] || o_wdata[k] !== e_wdata[k] || o_be[k] !== e_be[k])
                    $display("FAIL rnd%0d_req%0d: got %h/%b/%h/%h want %h/%b/%h/%h", it, k,
                             o_addr[k], o_we[k], o_wdata[k], o_be[k], e_addr[k], e_we[k], e_wdata[k], e_be[k]);
                else n_pass++;
            end
            n_chk++; if (vd_data !== e_vd || vd_be !== e_vdbe)
                $display("FAIL rnd%0d_vd: got be=%h want be=%h", it, vd_be, e_vdbe);
            else n_pass++;
            n_chk++; if (error !== e_err || pd !== 1'b0 || pb !== 1'b0)
                $display("FAIL rnd%0d_status: got err=%b done=%b busy=%b want %b 0 0", it, error, pd, pb, e_err);
            else n_pass++;
        end
        gnt_pct = 100; rv_dly = 0;
    endtask

    task automatic test_reset_abort();
        int t, cyc; bit pd, pb;
        set_op(1, 2'b00, 2'd2, 32'h300, 0, 4);
        rv_dly = 2;
        o_addr.delete(); o_we.delete(); o_wdata.delete(); o_be.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0;
        while (o_addr.size() < 3 && t < 200) begin @(posedge clk); t++; end
        n_chk++; if (o_addr.size() < 3) $display("FAIL ra_timeout: got %0d grants want 3", o_addr.size()); else n_pass++;
        #2;
        n_chk++; if (vd_be[7:0] !== 8'hFF || busy !== 1'b1)
            $display("FAIL ra_pre: got be=%h busy=%b want ff 1", vd_be[7:0], busy); else n_pass++;
        n_rst = 1'b0;
        #1;
        n_chk++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, done, error} !== '0 || vd_be !== '0 || vd_data !== '0)
            $display("FAIL ra_abort: got req=%b busy=%b done=%b be=%h want all 0", mem_req, busy, done, vd_be);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        set_op(1, 2'b00, 2'd2, 32'h400, 0, 3);
        rv_dly = 0;
        build_expect();
        run_op(0, cyc, pd, pb);
        n_chk++; if (o_addr.size() != 3 || o_addr[0] !== 32'h400)
            $display("FAIL ra_restart: got reqs=%0d first=%h want 3 400", o_addr.size(), (o_addr.size() > 0) ? o_addr[0] : 32'hX);
        else n_pass++;
        n_chk++; if (vd_data !== e_vd || vd_be !== e_vdbe || cyc != 8 || error !== 1'b0)
            $display("FAIL ra_result: got be=%h cyc=%0d err=%b want %h 8 0", vd_be, cyc, error, e_vdbe);
        else n_pass++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_unit_load();
        test_neg_stride_store();
        test_indexed_mask();
        test_edge_cases();
        test_grant_stall();
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
